// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by both the transmitter and the receiver:
//   - uart_state_e : frame FSM states
//   - PAR_NONE / PAR_EVEN / PAR_ODD : parity-mode encodings
//   - parity_bit() : parity bit for a (zero-extended) data word
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Zero-extension to 9 bits leaves the XOR unchanged, so one helper serves
  // every legal data width.
  function automatic logic parity_bit(input logic [8:0] data, input int mode);
    parity_bit = (^data) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen
// Bit-period timer. Counts 0..CLKS_PER_BIT-1 while enabled and wraps, so each
// bit boundary automatically restarts the count.
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   i_clear    : hold the count at zero
//   i_enable   : advance the count
//   o_bit_done : pulse on the last cycle of a bit period (count CLKS_PER_BIT-1)
//   o_pre_done : pulse one cycle before o_bit_done (count CLKS_PER_BIT-2)
// ---------------------------------------------------------------------------
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_bit_done,
  output logic o_pre_done
);

  localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] CNT_PRE  = 16'(CLKS_PER_BIT - 2);

  logic [15:0] r_cnt;

  // Bit-period counter with wrap at the end of each bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 16'd0;
    end else if (i_clear) begin
      r_cnt <= 16'd0;
    end else if (i_enable) begin
      if (r_cnt == CNT_LAST) begin
        r_cnt <= 16'd0;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_bit_done = i_enable & ~i_clear & (r_cnt == CNT_LAST);
  assign o_pre_done = i_enable & ~i_clear & (r_cnt == CNT_PRE);

endmodule

// File: rtl/uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// uart_tx_cfg
// Parameterised UART transmitter fed from a FIFO-style upstream.
// Frame: start(0), DATA_W data bits LSB first, optional parity, STOP_BITS
// stop bits(1); every bit lasts CLKS_PER_BIT cycles.
// Ports:
//   tx_clk    : clock, rising edge
//   rst_n     : asynchronous active-low reset (aborts any frame, tx high)
//   din_valid : upstream has a word
//   data_in   : word to send
//   rd_en     : ready; word accepted on an edge with rd_en & din_valid
//   tx        : serial line, idle high, driven from a register
//   busy      : high from the accept edge to the end of the last stop bit
// tx is the registered image of the current state, so the line trails the
// FSM by exactly one cycle and every bit still lasts CLKS_PER_BIT cycles.
// ---------------------------------------------------------------------------
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              tx_clk,
  input  logic              rst_n,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              rd_en,
  output logic              tx,
  output logic              busy
);

  generate
    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
      $error("uart_tx_cfg: DATA_W must be 5..9");
    end
    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks
      $error("uart_tx_cfg: CLKS_PER_BIT must be 2..65535");
    end
    if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_parity
      $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
  endgenerate

  localparam logic [3:0] LAST_DATA = 4'(DATA_W - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic       HAS_PAR   = (PARITY != PAR_NONE);

  uart_state_e       r_state;
  uart_state_e       w_state_nxt;
  logic [DATA_W-1:0] r_shift;
  logic              r_par;
  logic [3:0]        r_bit_cnt;
  logic              r_stop_cnt;
  logic              r_tx;
  logic              r_rd_en;
  logic              r_busy;

  logic w_accept;
  logic w_bit_done;
  logic w_pre_done;
  logic w_last_data;
  logic w_last_stop;
  logic w_tx_nxt;
  logic w_rd_en_nxt;
  logic w_baud_clear;

  assign w_accept     = r_rd_en & din_valid;
  assign w_last_data  = (r_bit_cnt == LAST_DATA);
  assign w_last_stop  = (r_stop_cnt == LAST_STOP);
  assign w_baud_clear = (r_state == ST_IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk       (tx_clk),
    .rst_n     (rst_n),
    .i_clear   (w_baud_clear),
    .i_enable  (~w_baud_clear),
    .o_bit_done(w_bit_done),
    .o_pre_done(w_pre_done)
  );

  // FSM state register.
  always_ff @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next line level.
  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_tx_nxt = 1'b1;
        if (w_accept) begin
          w_state_nxt = ST_START;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        w_tx_nxt = 1'b0;
        if (w_bit_done) begin
          w_state_nxt = ST_DATA;
        end else begin
          w_state_nxt = ST_START;
        end
      end
      ST_DATA: begin
        w_tx_nxt = r_shift[0];
        if (w_bit_done && w_last_data) begin
          if (HAS_PAR) begin
            w_state_nxt = ST_PAR;
          end else begin
            w_state_nxt = ST_STOP;
          end
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_PAR: begin
        w_tx_nxt = r_par;
        if (w_bit_done) begin
          w_state_nxt = ST_STOP;
        end else begin
          w_state_nxt = ST_PAR;
        end
      end
      ST_STOP: begin
        w_tx_nxt = 1'b1;
        if (w_bit_done && w_last_stop) begin
          // rd_en is high in this cycle, so w_accept means a back-to-back word.
          if (w_accept) begin
            w_state_nxt = ST_START;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_STOP;
        end
      end
      default: begin
        w_tx_nxt    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // rd_en is registered, so it is raised one cycle ahead: whenever the FSM is
  // heading to IDLE, and on the cycle before the last cycle of the last stop bit.
  assign w_rd_en_nxt = (w_state_nxt == ST_IDLE) |
                       ((r_state == ST_STOP) & w_last_stop & w_pre_done);

  // Registered outputs, word capture and bit/stop counters.
  always_ff @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx       <= 1'b1;
      r_rd_en    <= 1'b0;
      r_busy     <= 1'b0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_bit_cnt  <= 4'd0;
      r_stop_cnt <= 1'b0;
    end else begin
      r_tx    <= w_tx_nxt;
      r_rd_en <= w_rd_en_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      if (w_accept) begin
        r_shift    <= data_in;
        r_par      <= parity_bit(9'(data_in), PARITY);
        r_bit_cnt  <= 4'd0;
        r_stop_cnt <= 1'b0;
      end else if (r_state == ST_DATA && w_bit_done) begin
        r_shift   <= r_shift >> 1;
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end else if (r_state == ST_STOP && w_bit_done) begin
        r_stop_cnt <= r_stop_cnt + 1'b1;
      end else begin
        r_shift    <= r_shift;
        r_bit_cnt  <= r_bit_cnt;
        r_stop_cnt <= r_stop_cnt;
      end
    end
  end

  assign tx    = r_tx;
  assign rd_en = r_rd_en;
  assign busy  = r_busy;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_cfg
// Four configurations of uart_tx_cfg share one clock and reset:
//   u0 defaults (8,16,none,1)   u1 (8,16,even,2)
//   u2 (8,16,odd,1)             u3 (5,2,none,1)
// The reference model describes a frame as a list of bit values, each held
// CLKS_PER_BIT cycles, and derives busy/rd_en timing from the frame length.
// ---------------------------------------------------------------------------
module tb_uart_tx_cfg;

  localparam int NI = 4;
  localparam int DW  [NI] = '{8, 8, 8, 5};
  localparam int CPB [NI] = '{16, 16, 16, 2};
  localparam int PM  [NI] = '{0, 1, 2, 0};
  localparam int SB  [NI] = '{1, 2, 1, 1};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       dv     [NI];
  logic [8:0] din    [NI];
  logic       rd_o   [NI];
  logic       tx_o   [NI];
  logic       busy_o [NI];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_tx_cfg #(.DATA_W(8), .CLKS_PER_BIT(16), .PARITY(0), .STOP_BITS(1)) u0 (
    .tx_clk(clk), .rst_n(rst_n), .din_valid(dv[0]), .data_in(din[0][7:0]),
    .rd_en(rd_o[0]), .tx(tx_o[0]), .busy(busy_o[0]));
  uart_tx_cfg #(.DATA_W(8), .CLKS_PER_BIT(16), .PARITY(1), .STOP_BITS(2)) u1 (
    .tx_clk(clk), .rst_n(rst_n), .din_valid(dv[1]), .data_in(din[1][7:0]),
    .rd_en(rd_o[1]), .tx(tx_o[1]), .busy(busy_o[1]));
  uart_tx_cfg #(.DATA_W(8), .CLKS_PER_BIT(16), .PARITY(2), .STOP_BITS(1)) u2 (
    .tx_clk(clk), .rst_n(rst_n), .din_valid(dv[2]), .data_in(din[2][7:0]),
    .rd_en(rd_o[2]), .tx(tx_o[2]), .busy(busy_o[2]));
  uart_tx_cfg #(.DATA_W(5), .CLKS_PER_BIT(2), .PARITY(0), .STOP_BITS(1)) u3 (
    .tx_clk(clk), .rst_n(rst_n), .din_valid(dv[3]), .data_in(din[3][4:0]),
    .rd_en(rd_o[3]), .tx(tx_o[3]), .busy(busy_o[3]));

  function automatic int frame_len(input int k);
    return (1 + DW[k] + ((PM[k] != 0) ? 1 : 0) + SB[k]) * CPB[k];
  endfunction

  // Value of bit number idx within the frame carrying word w.
  function automatic logic frame_bit(input int k, input logic [8:0] w, input int idx);
    int ones;
    ones = 0;
    for (int i = 0; i < DW[k]; i++) ones += int'(w[i]);
    if (idx == 0) return 1'b0;
    if (idx <= DW[k]) return w[idx-1];
    if (PM[k] != 0 && idx == DW[k] + 1) return ((ones % 2) == 1) ^ (PM[k] == 2);
    return 1'b1;
  endfunction

  // Expected line level j edges after the first accept edge.
  function automatic logic exp_tx(input int k, input logic [8:0] w0, input logic [8:0] w1,
                                  input int n, input int j);
    int len;
    int m;
    int c;
    len = frame_len(k);
    if (j < 1 || j > n * len) return 1'b1;
    m = (j - 1) / len;
    c = (j - 1) % len;
    return frame_bit(k, (m == 0) ? w0 : w1, c / CPB[k]);
  endfunction

  task automatic chk(input string tag, input int k, input logic obs, input logic exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s[u%0d] t=%0t: observed %b expected %b", tag, k, $time, obs, exp_v);
    end
  endtask

  task automatic wait_idle(input int k);
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(negedge clk);
      if (rd_o[k] === 1'b1) ok = 1'b1;
    end
    chk("idle_wait", k, ok, 1'b1);
  endtask

  // Send n (1 or 2) words with din_valid held until the last one is taken.
  // With toggle set, data_in is scrambled after the last accept.
  task automatic run_seq(input int k, input logic [8:0] w0, input logic [8:0] w1,
                         input int n, input bit toggle);
    int len;
    len = frame_len(k);
    wait_idle(k);
    din[k] = w0;
    dv[k]  = 1'b1;
    for (int j = 0; j <= n * len + 1; j++) begin
      @(negedge clk);
      chk("tx", k, tx_o[k], exp_tx(k, w0, w1, n, j));
      if (j <= n * len) begin
        chk("busy", k, busy_o[k], logic'(j < n * len));
        chk("rd_en", k, rd_o[k], logic'(((j + 1) % len == 0) || (j == n * len)));
      end
      if (j == 0 && n == 2) din[k] = w1;
      if (j == (n - 1) * len) dv[k] = 1'b0;
      if (toggle && j >= (n - 1) * len) din[k] = 9'($urandom);
    end
  endtask

  // Reset u0 during its 4th data bit (w[3] must be 0 so the line visibly jumps).
  task automatic reset_mid(input logic [8:0] w);
    wait_idle(0);
    din[0] = w;
    dv[0]  = 1'b1;
    for (int j = 0; j <= 4 * CPB[0] + 5; j++) begin
      @(negedge clk);
      if (j == 0) dv[0] = 1'b0;
    end
    chk("tx_pre_rst", 0, tx_o[0], frame_bit(0, w, 4));
    rst_n = 1'b0;
    #1;
    chk("rst_tx", 0, tx_o[0], 1'b1);
    chk("rst_busy", 0, busy_o[0], 1'b0);
    chk("rst_rd_en", 0, rd_o[0], 1'b0);
    @(posedge clk);
    #1;
    chk("rst_hold_tx", 0, tx_o[0], 1'b1);
    chk("rst_hold_rd_en", 0, rd_o[0], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_rd_en_pre", 0, rd_o[0], 1'b0);
    @(posedge clk);
    #1;
    chk("rel_rd_en", 0, rd_o[0], 1'b1);
    chk("rel_busy", 0, busy_o[0], 1'b0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      chk("no_resume_tx", 0, tx_o[0], 1'b1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      dv[k]  = 1'b0;
      din[k] = 9'd0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("reset_tx", k, tx_o[k], 1'b1);
      chk("reset_rd_en", k, rd_o[k], 1'b0);
      chk("reset_busy", k, busy_o[k], 1'b0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) chk("first_rd_en", k, rd_o[k], 1'b1);

    // Directed frames for each configuration.
    run_seq(0, 9'h0A5, 9'h000, 1, 1'b0);
    run_seq(1, 9'h007, 9'h000, 1, 1'b0);
    run_seq(2, 9'h007, 9'h000, 1, 1'b0);
    run_seq(3, 9'h013, 9'h000, 1, 1'b0);
    // Back-to-back words, then data_in churn while busy.
    run_seq(0, 9'h055, 9'h0AA, 2, 1'b0);
    run_seq(0, 9'($urandom), 9'h000, 1, 1'b1);
    // Reset mid-frame, then an intact frame.
    reset_mid(9'h033);
    run_seq(0, 9'h0C3, 9'h000, 1, 1'b0);

    // Random words, configurations, burst lengths and churn.
    for (int r = 0; r < 10; r++) begin
      run_seq(int'($urandom_range(0, NI - 1)), 9'($urandom), 9'($urandom),
              int'($urandom_range(1, 2)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
